// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and MEM-stage requests, data first.
// Optional stall counters are compiled in when ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ireqF,
    input  logic [AW-1:0]    iaddrF,
    output logic [DW-1:0]    instrF,
    output logic             ireadyF,
    input  logic             dreqM,
    input  logic             dwriteM,
    input  logic [AW-1:0]    daddrM,
    input  logic [DW-1:0]    dwdataM,
    output logic [DW-1:0]    drdataM,
    output logic             dreadyM,
    output logic             stallF_mem,
    output logic             stallM_mem,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_ack,
    output logic             proto_err,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_i;
    logic   grant_d;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (dreqM) begin
                    state_nxt = DBUSY;
                    grant_d   = 1'b1;
                end else if (ireqF) begin
                    state_nxt = IBUSY;
                    grant_i   = 1'b1;
                end
            end
            IBUSY: begin
                if (mem_ack) begin
                    if (dreqM) begin
                        state_nxt = DBUSY;
                        grant_d   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DBUSY: begin
                // The served data request is not re-granted; fetch goes next.
                if (mem_ack) begin
                    if (ireqF) begin
                        state_nxt = IBUSY;
                        grant_i   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                mem_we    <= dwriteM;
                mem_addr  <= daddrM;
                mem_wdata <= dwdataM;
            end else if (grant_i) begin
                mem_we   <= 1'b0;
                mem_addr <= iaddrF;
            end
            if (mem_ack && state == IDLE) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign mem_req    = (state != IDLE);
    assign ireadyF    = (state == IBUSY) && mem_ack;
    assign dreadyM    = (state == DBUSY) && mem_ack;
    assign instrF     = mem_rdata;
    assign drdataM    = mem_rdata;
    assign stallF_mem = ireqF & ~ireadyF;
    assign stallM_mem = dreqM & ~dreadyM;

`ifdef ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] dcnt;

    // Saturating: a stuck counter reads as "at least this many".
    always_ff @(posedge clk) begin
        if (reset) begin
            icnt <= '0;
            dcnt <= '0;
        end else begin
            if (stallF_mem && icnt != CNT_MAX) begin
                icnt <= icnt + CNT_ONE;
            end
            if (stallM_mem && dcnt != CNT_MAX) begin
                dcnt <= dcnt + CNT_ONE;
            end
        end
    end

    assign istall_cnt = icnt;
    assign dstall_cnt = dcnt;
`else
    assign istall_cnt = '0;
    assign dstall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change 1ns after posedge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ireqF;
    logic [AW-1:0]    iaddrF;
    logic [DW-1:0]    instrF;
    logic             ireadyF;
    logic             dreqM;
    logic             dwriteM;
    logic [AW-1:0]    daddrM;
    logic [DW-1:0]    dwdataM;
    logic [DW-1:0]    drdataM;
    logic             dreadyM;
    logic             stallF_mem;
    logic             stallM_mem;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             mem_ack;
    logic             proto_err;
    logic [CNT_W-1:0] istall_cnt;
    logic [CNT_W-1:0] dstall_cnt;

    int passed = 0;
    int total  = 0;

    mem_port_arbiter #(
        .AW   (AW),
        .DW   (DW),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqF     (ireqF),
        .iaddrF    (iaddrF),
        .instrF    (instrF),
        .ireadyF   (ireadyF),
        .dreqM     (dreqM),
        .dwriteM   (dwriteM),
        .daddrM    (daddrM),
        .dwdataM   (dwdataM),
        .drdataM   (drdataM),
        .dreadyM   (dreadyM),
        .stallF_mem(stallF_mem),
        .stallM_mem(stallM_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .proto_err (proto_err),
        .istall_cnt(istall_cnt),
        .dstall_cnt(dstall_cnt)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ireqF     = 1'b0;
        iaddrF    = '0;
        dreqM     = 1'b0;
        dwriteM   = 1'b0;
        daddrM    = '0;
        dwdataM   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        sample();
        total++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            $display("FAIL reset_req_we: got req=%b we=%b want 0 0", mem_req, mem_we);
        end else passed++;
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            $display("FAIL reset_addr_wdata: got %h %h want 0 0", mem_addr, mem_wdata);
        end else passed++;
        total++;
        if (proto_err !== 1'b0 || ireadyF !== 1'b0 || dreadyM !== 1'b0) begin
            $display("FAIL reset_flags: got perr=%b ir=%b dr=%b want 0 0 0",
                     proto_err, ireadyF, dreadyM);
        end else passed++;
        total++;
        if (istall_cnt !== 4'd0 || dstall_cnt !== 4'd0) begin
            $display("FAIL reset_cnt: got %0d %0d want 0 0", istall_cnt, dstall_cnt);
        end else passed++;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        // cycle 0
        ireqF  = 1'b1;
        iaddrF = 32'h0040_0000;
        sample();
        total++;
        if (mem_req !== 1'b0 || stallF_mem !== 1'b1) begin
            $display("FAIL fetch_c0: got req=%b stall=%b want 0 1", mem_req, stallF_mem);
        end else passed++;
        // cycles 1-2
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            sample();
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_we !== 1'b0
                || stallF_mem !== 1'b1 || ireadyF !== 1'b0) begin
                $display("FAIL fetch_wait%0d: got req=%b addr=%h we=%b stall=%b rdy=%b want 1 00400000 0 1 0",
                         c, mem_req, mem_addr, mem_we, stallF_mem, ireadyF);
            end else passed++;
        end
        // cycle 3: ack
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C08_0004;
        sample();
        total++;
        if (ireadyF !== 1'b1 || instrF !== 32'h8C08_0004 || mem_req !== 1'b1
            || stallF_mem !== 1'b0 || dreadyM !== 1'b0) begin
            $display("FAIL fetch_ack: got rdy=%b instr=%h req=%b stall=%b drdy=%b want 1 8c080004 1 0 0",
                     ireadyF, instrF, mem_req, stallF_mem, dreadyM);
        end else passed++;
        // cycle 4
        next_cycle();
        idle_inputs();
        sample();
        total++;
        if (mem_req !== 1'b0 || ireadyF !== 1'b0) begin
            $display("FAIL fetch_done: got req=%b rdy=%b want 0 0", mem_req, ireadyF);
        end else passed++;
`ifdef ARB_PERF_EN
        total++;
        if (istall_cnt !== 4'd3) begin
            $display("FAIL istall_cnt: got %0d want 3", istall_cnt);
        end else passed++;
`else
        total++;
        if (istall_cnt !== 4'd0) begin
            $display("FAIL istall_tied: got %0d want 0", istall_cnt);
        end else passed++;
`endif
    endtask

    task automatic test_priority();
        ireqF   = 1'b1;
        iaddrF  = 32'h0040_0010;
        dreqM   = 1'b1;
        dwriteM = 1'b0;
        daddrM  = 32'h1001_0000;
        sample();
        total++;
        if (stallF_mem !== 1'b1 || stallM_mem !== 1'b1) begin
            $display("FAIL prio_stalls: got %b %b want 1 1", stallF_mem, stallM_mem);
        end else passed++;
        next_cycle();
        sample();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1001_0000 || mem_we !== 1'b0) begin
            $display("FAIL prio_dgrant: got req=%b addr=%h we=%b want 1 10010000 0",
                     mem_req, mem_addr, mem_we);
        end else passed++;
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        sample();
        total++;
        if (dreadyM !== 1'b1 || drdataM !== 32'h1122_3344 || ireadyF !== 1'b0) begin
            $display("FAIL prio_dack: got drdy=%b data=%h irdy=%b want 1 11223344 0",
                     dreadyM, drdataM, ireadyF);
        end else passed++;
        next_cycle();
        dreqM   = 1'b0;
        mem_ack = 1'b0;
        sample();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0010 || mem_we !== 1'b0) begin
            $display("FAIL prio_igrant: got req=%b addr=%h we=%b want 1 00400010 0",
                     mem_req, mem_addr, mem_we);
        end else passed++;
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0013;
        sample();
        total++;
        if (ireadyF !== 1'b1 || instrF !== 32'h0000_0013) begin
            $display("FAIL prio_iack: got rdy=%b instr=%h want 1 00000013", ireadyF, instrF);
        end else passed++;
        next_cycle();
        idle_inputs();
        sample();
        total++;
        if (mem_req !== 1'b0) begin
            $display("FAIL prio_idle: got req=%b want 0", mem_req);
        end else passed++;
    endtask

    task automatic test_store();
        dreqM   = 1'b1;
        dwriteM = 1'b1;
        daddrM  = 32'h1001_0004;
        dwdataM = 32'hDEAD_BEEF;
        next_cycle();
        sample();
        total++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1001_0004) begin
            $display("FAIL store_grant: got we=%b wdata=%h addr=%h want 1 deadbeef 10010004",
                     mem_we, mem_wdata, mem_addr);
        end else passed++;
        next_cycle();
        mem_ack = 1'b1;
        sample();
        total++;
        if (dreadyM !== 1'b1 || ireadyF !== 1'b0) begin
            $display("FAIL store_ack: got drdy=%b irdy=%b want 1 0", dreadyM, ireadyF);
        end else passed++;
        next_cycle();
        idle_inputs();
        sample();
        total++;
        if (mem_req !== 1'b0 || dreadyM !== 1'b0) begin
            $display("FAIL store_done: got req=%b drdy=%b want 0 0", mem_req, dreadyM);
        end else passed++;
    endtask

    task automatic test_flush();
        ireqF  = 1'b1;
        iaddrF = 32'h0040_0020;
        next_cycle();
        ireqF = 1'b0;
        sample();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0020) begin
            $display("FAIL flush_hold: got req=%b addr=%h want 1 00400020", mem_req, mem_addr);
        end else passed++;
        next_cycle();
        mem_ack = 1'b1;
        sample();
        total++;
        if (ireadyF !== 1'b1) begin
            $display("FAIL flush_ready: got %b want 1", ireadyF);
        end else passed++;
        next_cycle();
        idle_inputs();
        sample();
        total++;
        if (mem_req !== 1'b0) begin
            $display("FAIL flush_idle: got req=%b want 0", mem_req);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        dreqM  = 1'b1;
        daddrM = 32'h1001_0008;
        next_cycle();
        sample();
        total++;
        if (mem_req !== 1'b1) begin
            $display("FAIL rmid_busy: got req=%b want 1", mem_req);
        end else passed++;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        dreqM = 1'b0;
        sample();
        total++;
        if (mem_req !== 1'b0 || dreadyM !== 1'b0 || proto_err !== 1'b0 || mem_addr !== 32'h0) begin
            $display("FAIL rmid_state: got req=%b drdy=%b perr=%b addr=%h want 0 0 0 0",
                     mem_req, dreadyM, proto_err, mem_addr);
        end else passed++;
        next_cycle();
        ireqF  = 1'b1;
        iaddrF = 32'h0040_0040;
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        sample();
        total++;
        if (mem_addr !== 32'h0040_0040 || ireadyF !== 1'b1 || instrF !== 32'hCAFE_0001) begin
            $display("FAIL rmid_refetch: got addr=%h rdy=%b instr=%h want 00400040 1 cafe0001",
                     mem_addr, ireadyF, instrF);
        end else passed++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1;
        sample();
        total++;
        if (ireadyF !== 1'b0 || dreadyM !== 1'b0) begin
            $display("FAIL spur_ready: got %b %b want 0 0", ireadyF, dreadyM);
        end else passed++;
        next_cycle();
        mem_ack = 1'b0;
        sample();
        total++;
        if (proto_err !== 1'b1 || mem_req !== 1'b0) begin
            $display("FAIL spur_err: got perr=%b req=%b want 1 0", proto_err, mem_req);
        end else passed++;
        for (int c = 0; c < 3; c++) next_cycle();
        sample();
        total++;
        if (proto_err !== 1'b1) begin
            $display("FAIL spur_sticky: got %b want 1", proto_err);
        end else passed++;
        do_reset();
        sample();
        total++;
        if (proto_err !== 1'b0) begin
            $display("FAIL spur_clear: got %b want 0", proto_err);
        end else passed++;
    endtask

    task automatic test_dstall_sat();
        dreqM  = 1'b1;
        daddrM = 32'h1001_0010;
        for (int c = 0; c < 20; c++) next_cycle();
        mem_ack = 1'b1;
        sample();
        total++;
        if (dreadyM !== 1'b1) begin
            $display("FAIL dsat_ack: got %b want 1", dreadyM);
        end else passed++;
        next_cycle();
        idle_inputs();
        sample();
`ifdef ARB_PERF_EN
        total++;
        if (dstall_cnt !== 4'd15) begin
            $display("FAIL dstall_sat: got %0d want 15", dstall_cnt);
        end else passed++;
`else
        total++;
        if (dstall_cnt !== 4'd0) begin
            $display("FAIL dstall_tied: got %0d want 0", dstall_cnt);
        end else passed++;
`endif
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_flush();
        test_reset_mid();
        test_spurious_ack();
        test_dstall_sat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
